uart_tx: RTL
============

Name: uart_tx

Overview:
- Serialises one byte per valid/ready handshake onto an asynchronous UART line (LSB first), with optional parity and selectable stop-bit count.
- Upstream counterpart of uart_rx; its tx output drives the line that uart_rx samples.
- Configuration inputs use the same encoding as uart_rx, so a loopback (tx to rx) with identical settings must round-trip data and parity status.
- Baud timing comes from a fractional phase accumulator; no divider is used.

Parameters:
- CLK_FREQ, 25000000: clock frequency in Hz, used as the accumulator modulus.
- DATA_BITS, 8: payload bits per frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- baudrate  input  32  bit rate in baud; sampled at handshake.
- valid  input  1  tx_data_input is presented.
- tx_data_input  input  DATA_BITS  byte to send; sampled at handshake.
- stop_bits  input  2  0 = one stop bit; 1, 2 and 3 = two stop bits; sampled at handshake.
- parity_en  input  1  1 = append parity bit; sampled at handshake.
- parity_type  input  1  0 = even, 1 = odd; sampled at handshake.
- ready  output  1  block can accept a byte.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress.

Behaviour:
- Reset (rst low, asynchronous): tx=1, ready=0, busy=0, state IDLE, accumulator=0, shift register=0. On the first clock edge after rst deasserts, ready=1 if baudrate!=0.
- Handshake: a byte is accepted on a rising edge where valid && ready.
  - At that edge, data, parity setting and stop setting are latched and baudrate is captured.
  - ready becomes 0, busy becomes 1, tx becomes 0 (start bit begins the cycle after acceptance).
  - valid while not ready is ignored; the byte is not queued.
- ready = (state==IDLE) && (baudrate!=0). With baudrate==0, nothing is ever accepted.
- Baud tick (sub-module):
  - The 33-bit accumulator is cleared at acceptance.
  - Each cycle in a non-IDLE state: if acc+baud >= CLK_FREQ, then tick=1 and acc <= acc+baud-CLK_FREQ; otherwise acc <= acc+baud.
  - Each bit ends on a tick.
  - Captured baud above CLK_FREQ/2 is unsupported; behaviour is unspecified but the block must not deadlock.
- State machine (states in shared package):
  - IDLE: tx=1. Go to START on handshake.
  - START: tx=0. On tick, go to DATA with bit index 0.
  - DATA: tx=shift[0]. On tick, shift right and increment index. After bit DATA_BITS-1, go to PARITY if parity_en, else STOP.
  - PARITY: tx = ^data_latched XOR parity_type. On tick, go to STOP.
  - STOP: tx=1. On tick, if two stop bits and this is the first stop tick, stay in STOP; otherwise go to IDLE.
- In IDLE after STOP, ready=1 in that same cycle. The next byte may be accepted at the next edge, giving back-to-back frames with no extra idle bit.
- Frame length in cycles is exactly ceil(bits*CLK_FREQ/baud), where bits = 1 + DATA_BITS + parity_en + stop count.
- All outputs are registered; tx is glitch-free.
- Reset mid-frame: tx returns high immediately and the frame is abandoned; there is no partial completion.
- Input changes during a frame (config or data) have no effect on that frame.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum {IDLE, START, DATA, PARITY, STOP};
  - constants STOP_ONE=2'd0 and STOP_TWO=2'd1;
  - PARITY_EVEN=1'b0 and PARITY_ODD=1'b1;
  - a default baud constant of 115200.
- One sub-module, uart_baud_gen: phase-accumulator tick generator with inputs clk, rst, clear, enable, baud and output tick. It is reusable by uart_rx.

Test Plan:
- Reset: hold rst low, drive valid=1 -> tx=1, ready=0, busy=0. Release rst -> ready=1 one edge later; no frame starts until valid is sampled with ready=1.
- Send 0xA5, baud=115200, parity_en=1, parity_type=0, stop_bits=0 -> line bits 0,1,0,1,0,0,1,0,1 (parity 0),1. Start bit lasts 218 cycles. Whole frame lasts 2388 cycles, then ready=1.
- Same byte with parity_type=1 and stop_bits=1 -> parity bit 1, two stop bits, frame = ceil(12*25e6/115200) = 2605 cycles.
- Back-to-back: keep valid=1 with 0x00 then 0xFF, parity off -> second start bit follows the stop bit with no idle gap. tx pattern is 0,00000000,1,0,11111111,1.
- Assert rst mid-DATA -> tx=1 asynchronously (same cycle). After release, a fresh byte 0x3C transmits correctly.
- Loopback into uart_rx with identical config, 256 bytes -> every rx_data_output matches, and parity_valid asserts for each byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM states,
// stop-bit and parity encodings, and a default bit rate.
package uart_pkg;

    // Frame FSM states, shared with uart_rx so debug views line up.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // stop_bits encoding: 0 is one stop bit, any non-zero value is two.
    localparam logic [1:0] STOP_ONE = 2'd0;
    localparam logic [1:0] STOP_TWO = 2'd1;

    // parity_type encoding.
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam logic [31:0] DEFAULT_BAUD = 32'd115200;

    // True when the stop_bits setting asks for a second stop bit.
    function automatic logic two_stop(input logic [1:0] stop_bits);
        return stop_bits != STOP_ONE;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional phase-accumulator bit-rate generator. Every enabled cycle the
// accumulator advances by baud. When it reaches CLK_FREQ, one bit period has
// elapsed: tick is raised and the modulus is subtracted so the fractional
// remainder carries into the next bit. Long-term timing is therefore exact.
module uart_baud_gen #(
    parameter int CLK_FREQ = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] baud,
    output logic        tick
);

    localparam logic [33:0] MODULUS = 34'(CLK_FREQ);

    // The accumulator stays below max(CLK_FREQ, baud), so 33 bits always
    // hold it; the sum is one bit wider so it cannot wrap.
    logic [32:0] acc;
    logic [33:0] sum;

    assign sum  = {1'b0, acc} + {2'b00, baud};
    assign tick = enable && (sum >= MODULUS);

    // Advance the phase while a frame is in progress; restart from zero
    // when a new byte is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            if (tick) begin
                acc <= 33'(sum - MODULUS);
            end else begin
                acc <= sum[32:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. Accepts one byte per valid/ready handshake and sends it
// LSB first as: start bit, DATA_BITS data bits, optional parity, one or two
// stop bits. Bit timing comes from uart_baud_gen using the rate captured at
// acceptance.
//
// Handshake: a byte is taken on a rising edge where valid && ready. ready is
// high only while idle and baudrate is non-zero. Once taken, every setting
// for that frame is held internally, so inputs may change freely until the
// next handshake. valid while ready is low is ignored (nothing is queued).
// A byte is also refused if baudrate drops to zero in the same cycle, as a
// frame at zero rate would never finish.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 25000000,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          baudrate,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] tx_data_input,
    input  logic [1:0]           stop_bits,
    input  logic                 parity_en,
    input  logic                 parity_type,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e          state, state_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic                 stop2_q, stop2_n;
    logic [31:0]          baud_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 two_stop_q;
    logic                 tx_q, tx_n;
    logic                 ready_q;
    logic                 busy_q;
    logic                 accept;
    logic                 tick;

    assign accept = valid && ready_q && (baudrate != 32'd0);

    uart_baud_gen #(
        .CLK_FREQ(CLK_FREQ)
    ) u_baud_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .enable(state != IDLE),
        .baud  (baud_q),
        .tick  (tick)
    );

    // Next-state logic; each bit ends on a baud tick.
    always_comb begin
        state_n = state;
        shift_n = shift_q;
        idx_n   = idx_q;
        stop2_n = stop2_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    shift_n = tx_data_input;
                    idx_n   = '0;
                    stop2_n = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        state_n = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_n = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Line level for the next cycle, derived from the next state so tx can
    // come straight from a flop and never glitch.
    always_comb begin
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_bit_q;
            default: tx_n = 1'b1;
        endcase
    end

    // FSM, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            idx_q   <= idx_n;
            stop2_q <= stop2_n;
            tx_q    <= tx_n;
            ready_q <= (state_n == IDLE) && (baudrate != 32'd0);
            busy_q  <= (state_n != IDLE);
        end
    end

    // Per-frame settings, captured only at acceptance. The parity bit is
    // worked out once here rather than tracked bit by bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
        end else if (accept) begin
            baud_q     <= baudrate;
            par_en_q   <= parity_en;
            par_bit_q  <= (^tx_data_input) ^ (parity_type == PARITY_ODD);
            two_stop_q <= two_stop(stop_bits);
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule
